// File: rtl/spi_cmd_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module      : spi_cmd_dispatcher
//  Description : Turns a stream of SPI bytes into register-bus transactions.
//                The first byte of a frame is a command (rw, select, start
//                address); later bytes are write data, or dummy bytes that
//                pace a prefetching read burst. Sticky error flags report
//                byte overflow, bus timeout and bad peripheral select.
//  Revision    : 1.0  initial release
// ============================================================================
module spi_cmd_dispatcher #(
   parameter int NUM_PERIPH = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  iRST_n,
   input  logic                  iFRAME_ACTIVE,
   input  logic                  iBYTE_VALID,
   input  logic [7:0]            iBYTE,
   output logic [7:0]            oTX_BYTE,
   output logic                  oTX_LOAD,
   output logic [NUM_PERIPH-1:0] oBUS_SEL,
   output logic [2:0]            oBUS_ADDR,
   output logic [7:0]            oBUS_WDATA,
   output logic                  oBUS_WR,
   output logic                  oBUS_RD,
   input  logic                  iBUS_ACK,
   input  logic [7:0]            iBUS_RDATA,
   output logic                  oBUSY,
   output logic                  oERR_OVF,
   output logic                  oERR_TIMEOUT,
   output logic                  oERR_BADSEL
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      CMD      = 3'd1,
      WR_WAIT  = 3'd2,
      WR_REQ   = 3'd3,
      RD_REQ   = 3'd4,
      RD_WAIT  = 3'd5,
      DRAIN    = 3'd6
   } state_t;

   // Last wait-counter value at which an ack is still accepted.
   localparam logic [7:0] C_WAIT_LAST   = 8'(TIMEOUT - 1);
   localparam logic [4:0] C_NUM_PERIPH  = 5'(NUM_PERIPH);

   state_t                  state_q, state_d;
   logic [7:0]              wait_q, wait_d;
   logic                    frame_lost_q, frame_lost_d;
   logic [7:0]              tx_byte_q, tx_byte_d;
   logic                    tx_load_q, tx_load_d;
   logic [NUM_PERIPH-1:0]   bus_sel_q, bus_sel_d;
   logic [2:0]              bus_addr_q, bus_addr_d;
   logic [7:0]              bus_wdata_q, bus_wdata_d;
   logic                    bus_wr_q, bus_wr_d;
   logic                    bus_rd_q, bus_rd_d;
   logic                    busy_q, busy_d;
   logic                    err_ovf_q, err_ovf_d;
   logic                    err_to_q, err_to_d;
   logic                    err_bad_q, err_bad_d;

   logic [3:0]              w_cmd_sel;
   logic                    w_cmd_bad;
   logic                    w_lost;

   assign w_cmd_sel = iBYTE[6:3];
   assign w_cmd_bad = ({1'b0, w_cmd_sel} >= C_NUM_PERIPH);
   // A frame counts as lost if slave-select dropped at any point while the
   // current request was outstanding, even if it has since returned.
   assign w_lost    = frame_lost_q | ~iFRAME_ACTIVE;

   // Next-state and next-output decode for the dispatcher.
   always_comb begin
      state_d      = state_q;
      wait_d       = wait_q;
      frame_lost_d = frame_lost_q;
      tx_byte_d    = tx_byte_q;
      tx_load_d    = 1'b0;
      bus_sel_d    = bus_sel_q;
      bus_addr_d   = bus_addr_q;
      bus_wdata_d  = bus_wdata_q;
      bus_wr_d     = bus_wr_q;
      bus_rd_d     = bus_rd_q;
      err_ovf_d    = err_ovf_q;
      err_to_d     = err_to_q;
      err_bad_d    = err_bad_q;

      case (state_q)
         IDLE: begin
            if (iFRAME_ACTIVE) begin
               state_d   = CMD;
               err_ovf_d = 1'b0;
               err_to_d  = 1'b0;
               err_bad_d = 1'b0;
            end
         end

         CMD: begin
            if (!iFRAME_ACTIVE) begin
               state_d = IDLE;
            end else if (iBYTE_VALID) begin
               if (w_cmd_bad) begin
                  err_bad_d = 1'b1;
                  state_d   = DRAIN;
               end else begin
                  bus_sel_d  = NUM_PERIPH'(1'b1) << w_cmd_sel;
                  bus_addr_d = iBYTE[2:0];
                  if (iBYTE[7]) begin
                     state_d = WR_WAIT;
                  end else begin
                     state_d      = RD_REQ;
                     bus_rd_d     = 1'b1;
                     wait_d       = 8'd0;
                     frame_lost_d = 1'b0;
                  end
               end
            end
         end

         WR_WAIT: begin
            if (!iFRAME_ACTIVE) begin
               state_d = IDLE;
            end else if (iBYTE_VALID) begin
               state_d      = WR_REQ;
               bus_wdata_d  = iBYTE;
               bus_wr_d     = 1'b1;
               wait_d       = 8'd0;
               frame_lost_d = 1'b0;
            end
         end

         WR_REQ, RD_REQ: begin
            frame_lost_d = w_lost;
            // A byte arriving while the bus is busy is lost; the request
            // itself carries on unaffected.
            if (iBYTE_VALID) begin
               err_ovf_d = 1'b1;
            end
            if (iBUS_ACK) begin
               bus_wr_d   = 1'b0;
               bus_rd_d   = 1'b0;
               bus_addr_d = bus_addr_q + 3'd1;
               if (w_lost) begin
                  state_d = IDLE;
               end else if (state_q == RD_REQ) begin
                  tx_byte_d = iBUS_RDATA;
                  tx_load_d = 1'b1;
                  state_d   = RD_WAIT;
               end else begin
                  state_d = WR_WAIT;
               end
            end else if (wait_q == C_WAIT_LAST) begin
               bus_wr_d = 1'b0;
               bus_rd_d = 1'b0;
               err_to_d = 1'b1;
               state_d  = DRAIN;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end

         RD_WAIT: begin
            if (!iFRAME_ACTIVE) begin
               state_d = IDLE;
            end else if (iBYTE_VALID) begin
               state_d      = RD_REQ;
               bus_rd_d     = 1'b1;
               wait_d       = 8'd0;
               frame_lost_d = 1'b0;
            end
         end

         DRAIN: begin
            if (!iFRAME_ACTIVE) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d  = IDLE;
            bus_wr_d = 1'b0;
            bus_rd_d = 1'b0;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // State and registered outputs; reset wins over any pending request.
   always_ff @(posedge clk) begin
      if (!iRST_n) begin
         state_q      <= IDLE;
         wait_q       <= 8'd0;
         frame_lost_q <= 1'b0;
         tx_byte_q    <= 8'd0;
         tx_load_q    <= 1'b0;
         bus_sel_q    <= '0;
         bus_addr_q   <= 3'd0;
         bus_wdata_q  <= 8'd0;
         bus_wr_q     <= 1'b0;
         bus_rd_q     <= 1'b0;
         busy_q       <= 1'b0;
         err_ovf_q    <= 1'b0;
         err_to_q     <= 1'b0;
         err_bad_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         wait_q       <= wait_d;
         frame_lost_q <= frame_lost_d;
         tx_byte_q    <= tx_byte_d;
         tx_load_q    <= tx_load_d;
         bus_sel_q    <= bus_sel_d;
         bus_addr_q   <= bus_addr_d;
         bus_wdata_q  <= bus_wdata_d;
         bus_wr_q     <= bus_wr_d;
         bus_rd_q     <= bus_rd_d;
         busy_q       <= busy_d;
         err_ovf_q    <= err_ovf_d;
         err_to_q     <= err_to_d;
         err_bad_q    <= err_bad_d;
      end
   end

   assign oTX_BYTE     = tx_byte_q;
   assign oTX_LOAD     = tx_load_q;
   assign oBUS_SEL     = bus_sel_q;
   assign oBUS_ADDR    = bus_addr_q;
   assign oBUS_WDATA   = bus_wdata_q;
   assign oBUS_WR      = bus_wr_q;
   assign oBUS_RD      = bus_rd_q;
   assign oBUSY        = busy_q;
   assign oERR_OVF     = err_ovf_q;
   assign oERR_TIMEOUT = err_to_q;
   assign oERR_BADSEL  = err_bad_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_cmd_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_cmd_dispatcher
//  Description : Directed scenarios plus random SPI frames for the command
//                dispatcher, checked every cycle against a frame-level model
//                and a small peripheral memory.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_spi_cmd_dispatcher;

   localparam int NP = 4;
   localparam int TO = 5;
   localparam int VW = 26 + NP;

   logic          clk = 1'b0;
   logic          rst_n, frame, bv, ack;
   logic [7:0]    b_in, rdata;
   logic [7:0]    tx_byte, wdata;
   logic          tx_load, bus_wr, bus_rd, busy, e_ovf_o, e_to_o, e_bad_o;
   logic [NP-1:0] bus_sel;
   logic [2:0]    bus_addr;

   always #5 clk = ~clk;

   spi_cmd_dispatcher #(.NUM_PERIPH(NP), .TIMEOUT(TO)) dut (
      .clk(clk), .iRST_n(rst_n), .iFRAME_ACTIVE(frame), .iBYTE_VALID(bv),
      .iBYTE(b_in), .oTX_BYTE(tx_byte), .oTX_LOAD(tx_load),
      .oBUS_SEL(bus_sel), .oBUS_ADDR(bus_addr), .oBUS_WDATA(wdata),
      .oBUS_WR(bus_wr), .oBUS_RD(bus_rd), .iBUS_ACK(ack), .iBUS_RDATA(rdata),
      .oBUSY(busy), .oERR_OVF(e_ovf_o), .oERR_TIMEOUT(e_to_o), .oERR_BADSEL(e_bad_o)
   );

   int n_checks = 0;
   int n_err    = 0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- frame-level reference model ----------------
   bit          m_busy, m_have_cmd, m_is_wr, m_req, m_drain, m_lost;
   int          m_age;
   logic [7:0]  e_tx, e_wdata;
   logic        e_load, e_wr, e_rd, e_ovf, e_to, e_bad;
   logic [NP-1:0] e_sel;
   logic [2:0]  e_addr;

   task automatic issue(bit wr);
      m_req = 1; m_age = 0; m_lost = 0;
      e_wr = wr; e_rd = !wr;
   endtask

   task automatic model_step();
      int sel;
      if (!rst_n) begin
         m_busy = 0; m_have_cmd = 0; m_is_wr = 0; m_req = 0; m_drain = 0;
         m_lost = 0; m_age = 0;
         e_tx = 0; e_wdata = 0; e_load = 0; e_wr = 0; e_rd = 0;
         e_ovf = 0; e_to = 0; e_bad = 0; e_sel = '0; e_addr = 0;
         return;
      end
      e_load = 0;
      if (!m_busy) begin
         if (frame) begin
            m_busy = 1; m_have_cmd = 0; m_drain = 0;
            e_ovf = 0; e_to = 0; e_bad = 0;
         end
      end else if (m_drain) begin
         if (!frame) m_busy = 0;
      end else if (m_req) begin
         if (!frame) m_lost = 1;
         if (bv) e_ovf = 1;
         if (ack) begin
            m_req = 0;
            e_addr = 3'((e_addr + 1) % 8);
            if (m_lost) m_busy = 0;
            else if (e_rd) begin e_tx = rdata; e_load = 1; end
            e_wr = 0; e_rd = 0;
         end else begin
            m_age++;
            if (m_age >= TO) begin
               m_req = 0; e_wr = 0; e_rd = 0; e_to = 1; m_drain = 1;
            end
         end
      end else if (!frame) begin
         m_busy = 0;
      end else if (bv) begin
         if (!m_have_cmd) begin
            sel = int'(b_in[6:3]);
            if (sel >= NP) begin
               e_bad = 1; m_drain = 1;
            end else begin
               m_have_cmd = 1; m_is_wr = b_in[7];
               e_sel = '0; e_sel[sel] = 1'b1;
               e_addr = b_in[2:0];
               if (!m_is_wr) issue(0);
            end
         end else if (m_is_wr) begin
            e_wdata = b_in; issue(1);
         end else begin
            issue(0);
         end
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   // ---------------- per-cycle compare and monitors ----------------
   logic [VW-1:0] dut_vec, exp_vec;
   assign dut_vec = {tx_byte, tx_load, bus_sel, bus_addr, wdata, bus_wr, bus_rd,
                     busy, e_ovf_o, e_to_o, e_bad_o};
   assign exp_vec = {e_tx, e_load, e_sel, e_addr, e_wdata, e_wr, e_rd,
                     m_busy, e_ovf, e_to, e_bad};

   logic [7:0] load_q[$];
   int         req_starts = 0;
   int         wr_cycles  = 0;
   bit         prev_req   = 0;

   initial forever begin
      @(negedge clk);
      chk("cycle_outputs", 32'(dut_vec), 32'(exp_vec));
      if (tx_load === 1'b1) load_q.push_back(tx_byte);
      if ((bus_wr | bus_rd) && !prev_req) req_starts++;
      if (bus_wr === 1'b1) wr_cycles++;
      prev_req = bus_wr | bus_rd;
   end

   // ---------------- peripheral responder ----------------
   logic [7:0]  mem [16][8];
   logic [15:0] wr_log[$];
   logic [2:0]  rd_log[$];
   bit          ack_en = 1, rand_delay = 0, spur_en = 0;
   int          fixed_delay = 2, cur_delay = 0, req_age = 0;

   function automatic int onehot_idx(logic [NP-1:0] v);
      for (int i = 0; i < NP; i++) if (v[i]) return i;
      return 0;
   endfunction

   initial begin
      for (int p = 0; p < 16; p++)
         for (int a = 0; a < 8; a++) mem[p][a] = 8'($urandom);
      ack = 0; rdata = 0;
      forever begin
         @(posedge clk); #1;
         ack = 0;
         if (bus_wr | bus_rd) begin
            if (ack_en) begin
               if (req_age == 0) cur_delay = rand_delay ? int'($urandom_range(0, 6)) : fixed_delay;
               if (req_age == cur_delay) begin
                  ack = 1;
                  if (bus_wr) begin
                     mem[onehot_idx(bus_sel)][bus_addr] = wdata;
                     wr_log.push_back({1'b0, 4'(onehot_idx(bus_sel)), bus_addr, wdata});
                  end else begin
                     rdata = mem[onehot_idx(bus_sel)][bus_addr];
                     rd_log.push_back(bus_addr);
                  end
               end
               req_age++;
            end
         end else begin
            req_age = 0;
            if (spur_en && $urandom_range(0, 15) == 0) begin
               ack = 1; rdata = 8'($urandom);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic idle(int n);
      repeat (n) begin @(posedge clk); #1; bv = 0; end
   endtask

   task automatic send(logic [7:0] b);
      @(posedge clk); #1; bv = 1; b_in = b;
      @(posedge clk); #1; bv = 0;
   endtask

   initial begin
      int ws, ls, rs, wc, nb;
      rst_n = 0; frame = 0; bv = 0; b_in = 0;
      idle(3);
      chk("reset_outputs", 32'(dut_vec), 32'd0);
      rst_n = 1;
      idle(2);

      // Write burst 0x8E, A5, 3C with 2-cycle ack
      ws = wr_log.size();
      frame = 1; idle(2);
      send(8'h8E); idle(1);
      send(8'hA5); idle(6);
      send(8'h3C); idle(6);
      chk("wburst_count", 32'(wr_log.size() - ws), 32'd2);
      if (wr_log.size() - ws == 2) begin
         chk("wburst_w0", 32'(wr_log[ws]),   {16'd0, 1'b0, 4'd1, 3'd6, 8'hA5});
         chk("wburst_w1", 32'(wr_log[ws+1]), {16'd0, 1'b0, 4'd1, 3'd7, 8'h3C});
      end
      chk("wburst_mem6", 32'(mem[1][6]), 32'hA5);
      chk("wburst_sel",  32'(bus_sel), 32'b0010);
      chk("wburst_addr", 32'(bus_addr), 32'd0);
      chk("wburst_model_addr", 32'(e_addr), 32'd0);
      frame = 0; idle(2);
      chk("wburst_idle", 32'(busy), 32'd0);

      // Read prefetch 0x10 with data 0x11, 0x22
      mem[2][0] = 8'h11; mem[2][1] = 8'h22;
      ls = load_q.size(); rs = rd_log.size();
      frame = 1; idle(1);
      send(8'h10); idle(5);
      chk("rd_first_load_cnt", 32'(load_q.size() - ls), 32'd1);
      chk("rd_first_byte", 32'(tx_byte), 32'h11);
      send(8'h00); idle(5);
      chk("rd_second_load_cnt", 32'(load_q.size() - ls), 32'd2);
      chk("rd_second_byte", 32'(tx_byte), 32'h22);
      if (rd_log.size() - rs == 2) begin
         chk("rd_addr0", 32'(rd_log[rs]), 32'd0);
         chk("rd_addr1", 32'(rd_log[rs+1]), 32'd1);
      end else chk("rd_addr_count", 32'(rd_log.size() - rs), 32'd2);
      frame = 0; idle(2);

      // Bad select 0xA0
      rs = req_starts;
      frame = 1; idle(1);
      send(8'hA0); idle(2);
      chk("badsel_flag", 32'(e_bad_o), 32'd1);
      send(8'h80); idle(2);
      chk("badsel_noreq", 32'(req_starts), 32'(rs));
      chk("badsel_busy", 32'(busy), 32'd1);
      frame = 0; idle(2);
      chk("badsel_idle", 32'(busy), 32'd0);
      chk("badsel_sticky", 32'(e_bad_o), 32'd1);
      frame = 1; idle(2);
      chk("badsel_cleared", 32'(e_bad_o), 32'd0);
      frame = 0; idle(2);

      // Timeout on a write with no ack
      ack_en = 0;
      wc = wr_cycles;
      frame = 1; idle(1);
      send(8'h80); send(8'h55); idle(8);
      chk("to_wr_cycles", 32'(wr_cycles - wc), 32'(TO));
      chk("to_flag", 32'(e_to_o), 32'd1);
      chk("to_wr_low", 32'(bus_wr), 32'd0);
      rs = req_starts;
      send(8'h66); idle(3);
      chk("to_drain_noreq", 32'(req_starts), 32'(rs));
      frame = 0; idle(2);
      ack_en = 1;

      // Overflow: extra byte while write outstanding
      fixed_delay = 2;
      ws = wr_log.size();
      frame = 1; idle(1);
      send(8'h88); send(8'h77); send(8'h99); idle(5);
      chk("ovf_flag", 32'(e_ovf_o), 32'd1);
      chk("ovf_one_write", 32'(wr_log.size() - ws), 32'd1);
      if (wr_log.size() > ws)
         chk("ovf_write_data", 32'(wr_log[ws]), {16'd0, 1'b0, 4'd1, 3'd0, 8'h77});
      frame = 0; idle(2);

      // Collision: byte lands in the same cycle as the ack
      ws = wr_log.size();
      frame = 1; idle(1);
      send(8'h88); send(8'h77); idle(1); send(8'h99);
      chk("coll_wr_dropped", 32'(bus_wr), 32'd0);
      chk("coll_addr", 32'(bus_addr), 32'd1);
      chk("coll_ovf", 32'(e_ovf_o), 32'd1);
      idle(3);
      chk("coll_one_write", 32'(wr_log.size() - ws), 32'd1);
      frame = 0; idle(2);

      // Frame falls during a read request, ack 3 cycles later
      fixed_delay = 3;
      ls = load_q.size();
      frame = 1; idle(1);
      send(8'h18);
      frame = 0; idle(6);
      chk("lost_no_load", 32'(load_q.size() - ls), 32'd0);
      chk("lost_idle", 32'(busy), 32'd0);
      chk("lost_addr", 32'(bus_addr), 32'd1);

      // Reset during a write request
      ack_en = 0;
      frame = 1; idle(1);
      send(8'h80); send(8'h42);
      chk("rst_pre_wr", 32'(bus_wr), 32'd1);
      rst_n = 0; idle(1);
      chk("rst_all_zero", 32'(dut_vec), 32'd0);
      rst_n = 1; frame = 0; idle(2);
      ack_en = 1;

      // Random frames
      rand_delay = 1; spur_en = 1;
      repeat (150) begin
         frame = 1;
         idle(int'($urandom_range(0, 2)));
         send({1'($urandom), 4'($urandom_range(0, 5)), 3'($urandom)});
         nb = int'($urandom_range(0, 6));
         repeat (nb) begin
            idle(int'($urandom_range(0, 7)));
            send(8'($urandom));
         end
         if ($urandom_range(0, 3) != 0) idle(int'($urandom_range(0, 8)));
         frame = 0;
         idle(int'($urandom_range(1, 4)));
         if ($urandom_range(0, 19) == 0) begin
            rst_n = 0; idle(1); rst_n = 1;
         end
      end
      spur_en = 0;
      idle(12);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
